// File: rtl/inst_encoder_pkg.sv
// rtl/inst_encoder_pkg.sv - format codes, opcodes and FSM states shared by the instruction encoder
package inst_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    localparam logic [2:0] FT_R = 3'd0;
    localparam logic [2:0] FT_I = 3'd1;
    localparam logic [2:0] FT_S = 3'd2;
    localparam logic [2:0] FT_B = 3'd3;
    localparam logic [2:0] FT_U = 3'd4;
    localparam logic [2:0] FT_J = 3'd5;

    localparam logic [6:0] OP_FUNC1  = 7'b0010011;
    localparam logic [6:0] OP_FUNC2  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] INST_NOP = 32'h00000013;

    function automatic logic ft_legal(input logic [2:0] ft);
        return ft <= FT_J;
    endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// rtl/inst_encoder_pack.sv - combinational RV32I field packer; ENC_RANGE_CHECK_EN enables immediate range checks
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  ft_i,
    input  logic [6:0]  op_i,
    input  logic [2:0]  f3_i,
    input  logic [6:0]  f7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_err_o
);

    logic is_shift;
    logic unused_imm0;

    // Immediate shifts carry funct7 in the upper immediate bits.
    assign is_shift    = (op_i == OP_FUNC1) && ((f3_i == 3'b001) || (f3_i == 3'b101));
    assign unused_imm0 = imm_i[0];

    always_comb begin
        word_o = INST_NOP;
        case (ft_i)
            FT_R: word_o = {f7_i, rs2_i, rs1_i, f3_i, rd_i, op_i};
            FT_I: begin
                if (is_shift) word_o = {f7_i, imm_i[4:0], rs1_i, f3_i, rd_i, op_i};
                else          word_o = {imm_i[11:0], rs1_i, f3_i, rd_i, op_i};
            end
            FT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, f3_i, imm_i[4:0], op_i};
            FT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3_i,
                            imm_i[4:1], imm_i[11], op_i};
            FT_U: word_o = {imm_i[31:12], rd_i, op_i};
            FT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
            default: word_o = INST_NOP;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    always_comb begin
        range_err_o = 1'b0;
        case (ft_i)
            FT_I, FT_S: range_err_o = !((&imm_i[31:11]) || !(|imm_i[31:11]));
            FT_B: range_err_o = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
            FT_J: range_err_o = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
            FT_U: range_err_o = |imm_i[11:0];
            default: range_err_o = 1'b0;
        endcase
    end
`else
    assign range_err_o = 1'b0;
`endif

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - streams decoded fields into packed RV32I words written to IMEM; ENC_RANGE_CHECK_EN adds immediate checks
module inst_encoder
    import inst_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_ft,
    input  logic [6:0]  in_op,
    input  logic [2:0]  in_f3,
    input  logic [6:0]  in_f7,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_last,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    enc_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic [31:0] packed_word;
    logic        range_err;
    logic        bad_bundle;
    logic        accept;
    logic        complete;
    logic [1:0]  unused_base_lsb;

    assign unused_base_lsb = base_addr[1:0];

    inst_pack u_pack (
        .ft_i        (in_ft),
        .op_i        (in_op),
        .f3_i        (in_f3),
        .f7_i        (in_f7),
        .rd_i        (in_rd),
        .rs1_i       (in_rs1),
        .rs2_i       (in_rs2),
        .imm_i       (in_imm),
        .word_o      (packed_word),
        .range_err_o (range_err)
    );

    assign bad_bundle = !ft_legal(in_ft) || range_err;
    assign in_ready   = (state_q == ST_RUN) && (!we_q || imem_ready);
    assign accept     = in_valid && in_ready;
    assign complete   = we_q && imem_ready;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        count_d = count_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    addr_d  = {base_addr[31:2], 2'b00};
                    count_d = 16'd0;
                    err_d   = 1'b0;
                    we_d    = 1'b0;
                end
            end
            ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN: if (complete) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        // Completion and a new acceptance may share a cycle: the advance
        // happens once and the register is refilled by the accept below.
        if (complete) begin
            we_d   = 1'b0;
            addr_d = addr_q + 32'd4;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end

        if (accept) begin
            we_d    = 1'b1;
            wdata_d = bad_bundle ? INST_NOP : packed_word;
            if (bad_bundle) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - directed self-checking bench for inst_encoder
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_ft = 3'd0;
    logic [6:0]  in_op = 7'd0;
    logic [2:0]  in_f3 = 3'd0;
    logic [6:0]  in_f7 = 7'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        in_last = 1'b0;
    logic        imem_we;
    logic        imem_ready = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ft      (in_ft),
        .in_op      (in_op),
        .in_f3      (in_f3),
        .in_f7      (in_f7),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_ready (imem_ready),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base);
        start = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    task automatic drive(input logic [2:0] ft, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        in_valid = 1'b1;
        in_ft = ft; in_op = op; in_f3 = f3; in_f7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", imem_we); end
        total++; if (imem_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        total++; if (imem_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", imem_wdata); end
        total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, err}); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", word_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_start(32'h100);
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL single_base got=%h want=100", imem_addr); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", in_ready); end
        drive(FT_I, OP_FUNC1, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        step();
        idle_in();
        total++; if (imem_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b want=1", imem_we); end
        total++; if (imem_wdata !== 32'h00500093) begin bad++; $display("FAIL single_word got=%h want=00500093", imem_wdata); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL single_addr got=%h want=100", imem_addr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL single_done got=%b want=1", done); end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", word_count); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL single_we_off got=%b want=0", imem_we); end
    endtask

    task automatic test_back_to_back();
        do_start(32'h100);
        drive(FT_B, OP_BRANCH, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        step();
        total++; if (imem_wdata !== 32'h00208463) begin bad++; $display("FAIL b2b_beq got=%h want=00208463", imem_wdata); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL b2b_addr0 got=%h want=100", imem_addr); end
        drive(FT_J, OP_JAL, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0);
        step();
        total++; if (imem_wdata !== 32'hFFDFF06F) begin bad++; $display("FAIL b2b_jal got=%h want=ffdff06f", imem_wdata); end
        total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL b2b_addr1 got=%h want=104", imem_addr); end
        drive(FT_U, OP_LUI, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        step();
        idle_in();
        total++; if (imem_wdata !== 32'h123452B7) begin bad++; $display("FAIL b2b_lui got=%h want=123452b7", imem_wdata); end
        total++; if (imem_addr !== 32'h108) begin bad++; $display("FAIL b2b_addr2 got=%h want=108", imem_addr); end
        total++; if (word_count !== 16'd2) begin bad++; $display("FAIL b2b_count2 got=%0d want=2", word_count); end
        step();
        total++; if (done !== 1'b1 || word_count !== 16'd3) begin bad++; $display("FAIL b2b_end got=done%b/%0d want=done1/3", done, word_count); end
        total++; if (imem_addr !== 32'h10C) begin bad++; $display("FAIL b2b_addr_end got=%h want=10c", imem_addr); end
    endtask

    task automatic test_stall();
        do_start(32'h200);
        drive(FT_R, OP_FUNC2, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        step();
        imem_ready = 1'b0;
        drive(FT_S, OP_STORE, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (imem_we !== 1'b1 || imem_wdata !== 32'h002081B3 || imem_addr !== 32'h200 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got=we%b %h@%h rdy%b want=we1 002081b3@200 rdy0",
                         i, imem_we, imem_wdata, imem_addr, in_ready);
            end
        end
        imem_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b want=1", in_ready); end
        step();
        total++; if (imem_wdata !== 32'h0020A423 || imem_addr !== 32'h204) begin bad++; $display("FAIL stall_sw got=%h@%h want=0020a423@204", imem_wdata, imem_addr); end
        drive(FT_I, OP_FUNC1, 3'b101, 7'b0100000, 5'd1, 5'd2, 5'd0, 32'd3, 1'b1);
        step();
        idle_in();
        total++; if (imem_wdata !== 32'h40315093 || imem_addr !== 32'h208) begin bad++; $display("FAIL stall_srai got=%h@%h want=40315093@208", imem_wdata, imem_addr); end
        step();
        total++; if (done !== 1'b1 || word_count !== 16'd3) begin bad++; $display("FAIL stall_end got=done%b/%0d want=done1/3", done, word_count); end
    endtask

    task automatic test_illegal_ft();
        do_start(32'h400);
        drive(3'd7, OP_FUNC1, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        step();
        idle_in();
        total++; if (imem_wdata !== 32'h00000013) begin bad++; $display("FAIL illegal_nop got=%h want=00000013", imem_wdata); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b want=1", err); end
        step();
        total++; if (done !== 1'b1 || word_count !== 16'd1 || err !== 1'b1) begin bad++; $display("FAIL illegal_end got=done%b/%0d/err%b want=done1/1/err1", done, word_count, err); end
    endtask

    task automatic test_range();
        logic [31:0] exp_word;
        logic        exp_err;
`ifdef ENC_RANGE_CHECK_EN
        exp_word = 32'h00000013;
        exp_err  = 1'b1;
`else
        exp_word = 32'h80000093;
        exp_err  = 1'b0;
`endif
        do_start(32'h300);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL range_start_clears_err got=%b want=0", err); end
        drive(FT_I, OP_FUNC1, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1'b1);
        step();
        idle_in();
        total++; if (imem_wdata !== exp_word) begin bad++; $display("FAIL range_word got=%h want=%h", imem_wdata, exp_word); end
        total++; if (err !== exp_err) begin bad++; $display("FAIL range_err got=%b want=%b", err, exp_err); end
        step();
        total++; if (done !== 1'b1 || word_count !== 16'd1) begin bad++; $display("FAIL range_end got=done%b/%0d want=done1/1", done, word_count); end
    endtask

    task automatic test_wrap();
        do_start(32'hFFFFFFFF);
        total++; if (imem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_base got=%h want=fffffffc", imem_addr); end
        drive(FT_I, OP_FUNC1, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        step();
        total++; if (imem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_addr0 got=%h want=fffffffc", imem_addr); end
        drive(FT_U, OP_LUI, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        step();
        idle_in();
        total++; if (imem_addr !== 32'h0 || imem_wdata !== 32'h123452B7) begin bad++; $display("FAIL wrap_addr1 got=%h@%h want=123452b7@0", imem_wdata, imem_addr); end
        step();
        total++; if (imem_addr !== 32'h4 || word_count !== 16'd2) begin bad++; $display("FAIL wrap_end got=%h/%0d want=4/2", imem_addr, word_count); end
    endtask

    task automatic test_rst_drain();
        do_start(32'h500);
        drive(FT_I, OP_FUNC1, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        step();
        idle_in();
        imem_ready = 1'b0;
        step();
        total++; if (busy !== 1'b1 || imem_we !== 1'b1) begin bad++; $display("FAIL drain_pending got=busy%b we%b want=busy1 we1", busy, imem_we); end
        rst = 1'b1;
        step();
        total++;
        if (imem_we !== 1'b0 || imem_addr !== 32'd0 || imem_wdata !== 32'd0 || in_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || word_count !== 16'd0) begin
            bad++;
            $display("FAIL drain_rst got=we%b %h@%h rdy%b b%b d%b e%b n%0d want=all zero",
                     imem_we, imem_wdata, imem_addr, in_ready, busy, done, err, word_count);
        end
        rst = 1'b0;
        imem_ready = 1'b1;
        step();
        total++; if (imem_we !== 1'b0 || word_count !== 16'd0 || done !== 1'b0) begin bad++; $display("FAIL drain_no_write got=we%b n%0d d%b want=we0 n0 d0", imem_we, word_count, done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_illegal_ft();
        test_range();
        test_wrap();
        test_rst_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
